// File: rtl/wb_dma_reader.sv
// rtl/wb_dma_reader.sv - Wishbone block reader feeding a valid/ready stream through a FIFO
module wb_dma_reader #(
    parameter int fifo_aw = 4,
    parameter int timeout = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_adr,
    input  logic [15:0] word_cnt,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int depth = 1 << fifo_aw;
    localparam logic [fifo_aw:0]   fifo_full = {1'b1, {fifo_aw{1'b0}}};
    localparam logic [fifo_aw-1:0] ptr_one   = {{(fifo_aw-1){1'b0}}, 1'b1};
    localparam logic [fifo_aw:0]   cnt_one   = {{fifo_aw{1'b0}}, 1'b1};
    localparam bit                 tmo_en    = (timeout != 0);
    localparam logic [9:0]         tmo_last  = 10'(timeout - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        RECOVER,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [15:0] rem_q, rem_d;
    logic [9:0]  tcnt_q, tcnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cyc_q, cyc_d;

    logic              push, pop, flush;
    logic [31:0]       mem_q [depth];
    logic [fifo_aw-1:0] wr_ptr_q, rd_ptr_q;
    logic [fifo_aw:0]  count_q;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        tcnt_d  = tcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cyc_d   = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    adr_d   = base_adr & ~32'd3;
                    rem_d   = word_cnt;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (word_cnt == 16'd0) ? DRAIN : WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (count_q < fifo_full) begin
                    state_d = REQ;
                    cyc_d   = 1'b1;
                    tcnt_d  = 10'd0;
                end
            end
            REQ: begin
                // An ack in the timeout cycle still counts: ack is checked first.
                if (wb_ack_i) begin
                    push    = 1'b1;
                    adr_d   = adr_q + 32'd4;
                    rem_d   = rem_q - 16'd1;
                    state_d = RECOVER;
                end else if (tmo_en && tcnt_q == tmo_last) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cyc_d  = 1'b1;
                    tcnt_d = tcnt_q + 10'd1;
                end
            end
            RECOVER: begin
                state_d = (rem_q != 16'd0) ? WAIT_SPACE : DRAIN;
            end
            DRAIN: begin
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            tcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            tcnt_q  <= tcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
        end
    end

    assign pop = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ptr_one;
            if (pop)  rd_ptr_q <= rd_ptr_q + ptr_one;
            if (push && !pop)      count_q <= count_q + cnt_one;
            else if (pop && !push) count_q <= count_q - cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wb_dat_i;
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 32'd0;

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = 1'b0;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = 4'b1111;

endmodule

// File: doc/wb_dma_reader.md
Name: wb_dma_reader

Overview:
- Wishbone master that fetches a block of 32-bit words from a Wishbone slave (e.g. the 16-bit SRAM controller) and delivers them on a valid/ready stream through an internal FIFO.
- The initiator side of the same bus: it issues classic single reads, one outstanding at a time, and throttles on FIFO space.
- Feeds consumers such as a framebuffer scanout or a CPU-to-peripheral copy engine.

Parameters:
- fifo_aw, 4: FIFO address width; the FIFO holds 2**fifo_aw words.
- timeout, 255: maximum cycles to wait for wb_ack_i in a request (1..1023); 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; starts a transfer; ignored while busy=1
- base_adr  in  32  byte address of the first word; bits [1:0] ignored (treated as 00)
- word_cnt  in  16  number of 32-bit words to read; 0 is legal
- busy  out  1  high from the cycle after start until the transfer finishes
- done  out  1  one-cycle pulse at the end of a transfer (normal or aborted)
- error  out  1  set by a timeout; held until the next accepted start
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  constant 0
- wb_adr_o  out  32  byte address; bits [1:0] always 00
- wb_sel_o  out  4  constant 4'b1111
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- out_valid  out  1  stream data valid
- out_ready  in  1  consumer ready; a transfer happens when valid and ready are both high
- out_data  out  32  stream data

Behaviour:
- Reset (asynchronous) forces every output to 0, empties the FIFO, clears the counters and sends the FSM to IDLE. Reset mid-transfer drops wb_cyc_o/wb_stb_o immediately and discards the transfer.
- FSM states: IDLE, WAIT_SPACE, REQ, RECOVER, DRAIN.
- IDLE:
  - start=1 latches base_adr&~3 into adr, word_cnt into remaining, and clears error; busy goes high the next cycle.
  - If word_cnt=0, go to DRAIN (FIFO empty, so done pulses the next cycle with no bus activity). Otherwise go to WAIT_SPACE.
- WAIT_SPACE: when fifo_count < 2**fifo_aw, go to REQ.
- REQ:
  - wb_cyc_o=wb_stb_o=1 and wb_adr_o=adr, all registered.
  - On wb_ack_i=1: push wb_dat_i into the FIFO, adr+=4 (wraps modulo 2**32), remaining-=1, go to RECOVER.
  - The push is guaranteed room because space was checked with a single read outstanding.
- RECOVER:
  - wb_cyc_o=wb_stb_o=0 for exactly one cycle; this is mandatory because the slave qualifies new requests on ack low.
  - Then go to WAIT_SPACE if remaining!=0, else DRAIN.
- DRAIN: when the FIFO is empty, pulse done, drop busy, go to IDLE.
- Timeout:
  - In REQ a cycle counter clears on entry. If it reaches the timeout value without an ack, the block drops cyc/stb, sets error, flushes the FIFO, and goes to DRAIN.
  - The FIFO is now empty, so done pulses on the following cycle.
  - An ack arriving in the same cycle as the timeout wins: the data is pushed and no error is raised.
- Timing: start sampled at cycle 0, so wb_stb_o is high at cycle 2 (IDLE->WAIT_SPACE->REQ). An ack at cycle n puts the word on out_valid at cycle n+1. The earliest next strobe is cycle n+3, giving a throughput of ack-latency+3 cycles per word.
- FIFO:
  - Synchronous, first-word registered on out_data.
  - A simultaneous push and pop keeps the count unchanged.
  - out_data is stable while out_valid=1 and out_ready=0.
- Ack outside REQ (spurious) is ignored: no push.
- start while busy=1 is ignored, with no effect on any state.
- done and a new start may not coincide, because start is ignored while busy.

Test Plan:
- base_adr=0x100, word_cnt=4, slave acks 2 cycles after each stb, out_ready=1 -> reads at 0x100, 0x104, 0x108, 0x10C; out_data sequence matches slave memory; stb low at least 1 cycle between requests; one done pulse; error=0.
- word_cnt=0 -> no wb_cyc_o; done pulses 2 cycles after start; busy high for 1 cycle.
- fifo_aw=2, word_cnt=10, out_ready=0 -> exactly 4 acks then the bus idles in WAIT_SPACE. Raise out_ready -> all 10 words delivered in order, then done.
- base_adr=0x0000_0003, word_cnt=2 -> addresses 0x0, 0x4.
- base_adr=0xFFFF_FFFC, word_cnt=2 -> second address wraps to 0x0000_0000.
- timeout=8, slave never acks -> cyc/stb drop after 8 cycles in REQ; error=1; done pulses; FIFO empty. The next start clears error.
- Assert reset during the 3rd REQ of a 6-word transfer -> cyc/stb/busy/out_valid are 0 in the same cycle. After release, a new start=1 with word_cnt=1 completes normally.
